// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants plus the line-advance and decode helpers
// used by both the horizontal counter and the vertical sync generator.
package vga_timing_pkg;

   localparam int unsigned COORD_W      = 10;

   localparam int unsigned H_VIS        = 640;
   localparam int unsigned H_SYNC_START = 656;
   localparam int unsigned H_SYNC_END   = 751;
   localparam int unsigned H_TOTAL      = 800;

   localparam int unsigned V_VIS        = 480;
   localparam int unsigned V_SYNC_START = 490;
   localparam int unsigned V_SYNC_END   = 491;
   localparam int unsigned V_TOTAL      = 525;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic vis;
      logic hs_act;
      logic vs_act;
   } timing_dec_t;

   function automatic coord_t next_line(input coord_t v);
      return (v == coord_t'(V_TOTAL - 1)) ? '0 : v + coord_t'(1);
   endfunction

   // Out-of-range h values (>= H_TOTAL) fall outside every window, i.e. blanking.
   function automatic timing_dec_t decode(input logic [15:0] h, input coord_t y);
      timing_dec_t d;
      d.vis    = (h < 16'(H_VIS)) && (y < coord_t'(V_VIS));
      d.hs_act = (h >= 16'(H_SYNC_START)) && (h <= 16'(H_SYNC_END));
      d.vs_act = (y >= coord_t'(V_SYNC_START)) && (y <= coord_t'(V_SYNC_END));
      return d;
   endfunction

endpackage

// File: rtl/frame_divider.sv
// Divides frame boundaries into game steps; the speed setting is sampled only
// at a step so a change waits for the current interval to finish.
module frame_divider
   import vga_timing_pkg::*;
(
   input  logic       vga_clk,
   input  logic       rst,
   input  logic       fb,
   input  logic [3:0] speed_sel,
   input  logic       pause,
   output logic       game_tick
);

   logic [3:0] fcnt_q, fcnt_d;
   logic [3:0] spd_lat_q, spd_lat_d;
   logic       step;

   always_comb begin
      fcnt_d    = fcnt_q;
      spd_lat_d = spd_lat_q;
      step      = 1'b0;
      if (fb) begin
         if (fcnt_q >= spd_lat_q) begin
            fcnt_d    = 4'd0;
            spd_lat_d = speed_sel;
            step      = 1'b1;
         end else begin
            fcnt_d = fcnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         fcnt_q    <= 4'd0;
         spd_lat_q <= 4'd0;
         game_tick <= 1'b0;
      end else begin
         fcnt_q    <= fcnt_d;
         spd_lat_q <= spd_lat_d;
         // A paused step is simply dropped; the interval still restarts.
         game_tick <= step && !pause;
      end
   end

endmodule

// File: rtl/vert_sync_gen.sv
// Vertical line counter and registered 640x480 sync/video/coordinate outputs,
// driven by the upstream horizontal count and its line-start strobe.
module vert_sync_gen
   import vga_timing_pkg::*;
(
   input  logic         vga_clk,
   input  logic         rst,
   input  logic [15:0]  h_value,
   input  logic         v_count_enable,
   input  logic [3:0]   speed_sel,
   input  logic         pause,
   output logic         hsync,
   output logic         vsync,
   output logic         video_on,
   output logic [9:0]   pixel_x,
   output logic [9:0]   pixel_y,
   output logic         frame_tick,
   output logic         game_tick
);

   coord_t      v_cnt_q;
   coord_t      v_next;
   coord_t      y_eff;
   timing_dec_t dec;
   logic        fb;

   // Look ahead at line start so column 0 decodes with its own line number.
   always_comb begin
      v_next = next_line(v_cnt_q);
      y_eff  = v_count_enable ? v_next : v_cnt_q;
      fb     = v_count_enable && (v_next == '0);
      dec    = decode(h_value, y_eff);
   end

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         v_cnt_q <= '0;
      end else if (v_count_enable) begin
         v_cnt_q <= v_next;
      end
   end

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         video_on   <= 1'b0;
         pixel_x    <= 10'd0;
         pixel_y    <= 10'd0;
         frame_tick <= 1'b0;
      end else begin
         hsync      <= !dec.hs_act;
         vsync      <= !dec.vs_act;
         video_on   <= dec.vis;
         pixel_x    <= dec.vis ? h_value[9:0] : 10'd0;
         pixel_y    <= dec.vis ? y_eff : 10'd0;
         frame_tick <= fb;
      end
   end

   frame_divider u_frame_divider (
      .vga_clk   (vga_clk),
      .rst       (rst),
      .fb        (fb),
      .speed_sel (speed_sel),
      .pause     (pause),
      .game_tick (game_tick)
   );

endmodule

// File: tb/tb_vert_sync_gen.sv
// Directed bench for vert_sync_gen: decode vector table, then line, frame,
// game-step and mid-frame reset sequences using compressed line strobes.
module tb_vert_sync_gen;

   logic        vga_clk = 1'b0;
   logic        rst;
   logic [15:0] h_value;
   logic        v_count_enable;
   logic [3:0]  speed_sel;
   logic        pause;
   logic        hsync, vsync, video_on, frame_tick, game_tick;
   logic [9:0]  pixel_x, pixel_y;

   int checks = 0;
   int errors = 0;
   int orphan = 0;

   vert_sync_gen dut (
      .vga_clk        (vga_clk),
      .rst            (rst),
      .h_value        (h_value),
      .v_count_enable (v_count_enable),
      .speed_sel      (speed_sel),
      .pause          (pause),
      .hsync          (hsync),
      .vsync          (vsync),
      .video_on       (video_on),
      .pixel_x        (pixel_x),
      .pixel_y        (pixel_y),
      .frame_tick     (frame_tick),
      .game_tick      (game_tick)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int          pre;
      logic [15:0] h;
      logic        en;
      logic        hs, vs, von;
      logic [9:0]  px, py;
      logic        ft, gt;
   } vec_t;

   vec_t vecs[20];

   function automatic int pack(input logic hs, input logic vs, input logic von,
                               input logic [9:0] px, input logic [9:0] py,
                               input logic ft, input logic gt);
      return int'({hs, vs, von, px, py, ft, gt});
   endfunction

   function automatic int dut_pack();
      return pack(hsync, vsync, video_on, pixel_x, pixel_y, frame_tick, game_tick);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle; on return the registered outputs reflect these inputs.
   task automatic cyc(input logic [15:0] h, input logic en);
      h_value        = h;
      v_count_enable = en;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) cyc(16'd0, 1'b1);
   endtask

   int hs_lo, vs_lo, von_hi;

   task automatic run_line();
      for (int h = 0; h < 800; h++) begin
         cyc(16'(h), h == 0);
         if (!hsync) hs_lo++;
         if (!vsync) vs_lo++;
         if (video_on) von_hi++;
      end
   endtask

   task automatic wait_fb(output int n, output logic gt);
      bit found;
      found = 1'b0;
      n     = 0;
      gt    = 1'b0;
      while (!found && n < 600) begin
         cyc(16'd0, 1'b1);
         n++;
         if (game_tick && !frame_tick) orphan++;
         if (frame_tick) begin
            found = 1'b1;
            gt    = game_tick;
         end
      end
      if (!found) n = -1;
   endtask

   int   n;
   logic gt;
   logic exp_c[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      //         pre  h         en    hs    vs    von   px       py       ft    gt
      vecs[0]  = '{0,   16'd0,   1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[1]  = '{0,   16'd639, 1'b0, 1'b1, 1'b1, 1'b1, 10'd639, 10'd0,   1'b0, 1'b0};
      vecs[2]  = '{0,   16'd640, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[3]  = '{0,   16'd655, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[4]  = '{0,   16'd656, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[5]  = '{0,   16'd751, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[6]  = '{0,   16'd752, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[7]  = '{0,   16'd900, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[8]  = '{0,   16'd0,   1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1,   1'b0, 1'b0};
      vecs[9]  = '{0,   16'd5,   1'b0, 1'b1, 1'b1, 1'b1, 10'd5,   10'd1,   1'b0, 1'b0};
      vecs[10] = '{478, 16'd100, 1'b0, 1'b1, 1'b1, 1'b1, 10'd100, 10'd479, 1'b0, 1'b0};
      vecs[11] = '{0,   16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[12] = '{9,   16'd10,  1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[13] = '{0,   16'd0,   1'b1, 1'b1, 1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[14] = '{0,   16'd700, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[15] = '{1,   16'd10,  1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[16] = '{0,   16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[17] = '{31,  16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0};
      vecs[18] = '{0,   16'd0,   1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1};
      vecs[19] = '{0,   16'd1,   1'b0, 1'b1, 1'b1, 1'b1, 10'd1,   10'd0,   1'b0, 1'b0};

      rst            = 1'b1;
      h_value        = 16'd0;
      v_count_enable = 1'b0;
      speed_sel      = 4'd0;
      pause          = 1'b0;
      repeat (3) @(posedge vga_clk);
      #1;
      chk("reset_state", dut_pack(), pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0));
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         strobes(vecs[i].pre);
         cyc(vecs[i].h, vecs[i].en);
         chk($sformatf("vec%0d", i), dut_pack(),
             pack(vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].px, vecs[i].py,
                  vecs[i].ft, vecs[i].gt));
      end

      // One full visible line (line 1).
      hs_lo = 0; vs_lo = 0; von_hi = 0;
      run_line();
      chk("line_hsync_low", hs_lo, 96);
      chk("line_video_on", von_hi, 640);
      chk("line_vsync_low", vs_lo, 0);

      // Full lines 489..492 around the vsync pulse.
      strobes(487);
      hs_lo = 0; vs_lo = 0; von_hi = 0;
      repeat (4) run_line();
      chk("vsync_low_cycles", vs_lo, 1600);
      chk("vblank_hsync_low", hs_lo, 384);
      chk("vblank_video_on", von_hi, 0);

      wait_fb(n, gt);
      chk("fb_from_492", n, 33);
      chk("fb_gt_speed0", int'(gt), 1);
      wait_fb(n, gt);
      chk("fb_period", n, 525);
      chk("fb_gt_speed0b", int'(gt), 1);

      // speed_sel=3: steps on frames 0, 4, 8.
      speed_sel = 4'd3;
      for (int f = 0; f < 9; f++) begin
         wait_fb(n, gt);
         chk($sformatf("spd3_frame%0d_period", f), n, 525);
         chk($sformatf("spd3_frame%0d_gt", f), int'(gt), int'(exp_c[f]));
      end

      // Speed change two frames after a step waits out the current interval.
      wait_fb(n, gt); chk("chg_f9_gt", int'(gt), 0);
      wait_fb(n, gt); chk("chg_f10_gt", int'(gt), 0);
      speed_sel = 4'd0;
      wait_fb(n, gt); chk("chg_f11_gt", int'(gt), 0);
      wait_fb(n, gt); chk("chg_f12_gt", int'(gt), 1);
      wait_fb(n, gt); chk("chg_f13_gt", int'(gt), 1);
      wait_fb(n, gt); chk("chg_f14_gt", int'(gt), 1);

      // Pause across a step frame keeps the spacing.
      speed_sel = 4'd1;
      wait_fb(n, gt); chk("pause_a_gt", int'(gt), 1);
      wait_fb(n, gt); chk("pause_b_gt", int'(gt), 0);
      pause = 1'b1;
      wait_fb(n, gt); chk("pause_c_ft", n, 525); chk("pause_c_gt", int'(gt), 0);
      pause = 1'b0;
      wait_fb(n, gt); chk("pause_d_gt", int'(gt), 0);
      wait_fb(n, gt); chk("pause_e_gt", int'(gt), 1);
      chk("orphan_game_tick", orphan, 0);

      // Mid-frame reset at line 300, h=400.
      strobes(300);
      cyc(16'd400, 1'b0);
      chk("pre_reset_pix", dut_pack(),
          pack(1'b1, 1'b1, 1'b1, 10'd400, 10'd300, 1'b0, 1'b0));
      rst = 1'b1;
      #1;
      chk("async_reset", dut_pack(), pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0));
      cyc(16'd400, 1'b0);
      chk("in_reset_0", dut_pack(), pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0));
      cyc(16'd700, 1'b0);
      chk("in_reset_1", dut_pack(), pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0));
      cyc(16'd0, 1'b1);
      chk("in_reset_2", dut_pack(), pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0));
      rst = 1'b0;
      cyc(16'd5, 1'b0);
      chk("post_reset_line0", dut_pack(),
          pack(1'b1, 1'b1, 1'b1, 10'd5, 10'd0, 1'b0, 1'b0));
      cyc(16'd0, 1'b1);
      chk("post_reset_line1", dut_pack(),
          pack(1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 1'b0, 1'b0));
      wait_fb(n, gt);
      chk("post_reset_first_fb", n, 524);
      chk("post_reset_first_gt", int'(gt), 1);
      wait_fb(n, gt);
      chk("post_reset_second_gt", int'(gt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vert_sync_gen.md
# vert_sync_gen

Downstream stage of the horizontal pixel counter in the VGA path. Consumes the 0..799 horizontal count and its one-cycle line-wrap strobe, and maintains the vertical line count (0..524). Produces registered 640x480@60 sync, video-enable and pixel coordinates for the snake renderer, plus a frame strobe and a speed-programmable game-step tick for the game logic.

## Interface
- H_VIS, 640, visible pixels per line
- H_SYNC_START, 656, first hsync-active column
- H_SYNC_END, 751, last hsync-active column
- V_VIS, 480, visible lines
- V_SYNC_START, 490, first vsync-active line
- V_SYNC_END, 491, last vsync-active line
- V_TOTAL, 525, lines per frame
- vga_clk  in  1  pixel clock, shared with the horizontal counter
- rst  in  1  asynchronous, active-high reset
- h_value  in  16  horizontal count, 0..799, from upstream counter
- v_count_enable  in  1  high for exactly the cycle in which h_value==0 (line start)
- speed_sel  in  4  frames per game step minus 1 (0 means every frame)
- pause  in  1  suppresses game_tick; frame counting continues
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  pixel is in the visible region
- pixel_x  out  10  visible column; 0 when not visible
- pixel_y  out  10  visible line; 0 when not visible
- frame_tick  out  1  one-cycle pulse at pixel (0,0) of each frame
- game_tick  out  1  one-cycle pulse every speed_sel+1 frames, coincident with frame_tick

## Operation
- Line counter v_cnt (10 bits). On each posedge with v_count_enable=1: v_cnt <= (v_cnt==V_TOTAL-1) ? 0 : v_cnt+1.
- Effective line y_eff = v_count_enable ? next(v_cnt) : v_cnt. This lookahead ensures column 0 of a line decodes with its own line number.
- Decode, all from h_value and y_eff:
  - vis = (h_value < H_VIS) && (y_eff < V_VIS).
  - hs_act = H_SYNC_START <= h_value <= H_SYNC_END.
  - vs_act = V_SYNC_START <= y_eff <= V_SYNC_END.
- h_value > 799 (should never happen) is treated as blanking with no hsync. The block never modifies or checks the upstream count.
- Frame boundary: fb = v_count_enable && next(v_cnt)==0.
- Frame step counter fcnt (4 bits):
  - On fb: if fcnt >= spd_lat, fcnt <= 0, step=1 and spd_lat <= speed_sel; otherwise fcnt <= fcnt+1.
  - spd_lat is loaded only at a step, so a mid-interval speed change takes effect after the current interval.
  - game_tick = step && !pause. A paused step is dropped and fcnt still wraps.

## Timing
- All outputs are registered, with 1-cycle latency from the h_value/v_count_enable inputs. Example: h_value=656 at edge N gives hsync=0 after edge N+1.
- pixel_x = vis ? h_value[9:0] : 0, and pixel_y = vis ? y_eff : 0, in the same register stage as video_on.
- frame_tick is high for exactly one cycle per 420 000 cycles in steady state.
- game_tick, when issued, is high in the same cycle as frame_tick.
- Reset (asynchronous, at any point including mid-frame) sets:
  - v_cnt=0, fcnt=0, spd_lat=0;
  - hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_tick=0, game_tick=0.
- After reset release, the first frame_tick occurs at the first fb, i.e. after 524 line strobes. The first line after reset counts as line 0 only if reset was released while h_value was still free-running. No resynchronisation to the upstream counter is attempted.
- Simultaneous fb and speed_sel change: the old spd_lat decides this step, and the new value is latched only if this fb is a step.

## Structure
- Shared package vga_timing_pkg holds the 640x480 constants (H/V visible, porch, sync and total values) and the 10-bit coordinate width. Both the horizontal counter and this block reference it.
- Optional sub-module frame_divider, containing fcnt, spd_lat and the game_tick logic, driven by fb, speed_sel and pause. Everything else stays flat.

## Test plan
- Drive a model of the 0..799 counter from reset for 2 frames. Check:
  - hsync low for exactly 96 cycles per line;
  - vsync low for exactly 2 lines (1600 cycles);
  - video_on high for 640x480 cycles per frame;
  - frame_tick period of 420 000 cycles.
- Sample at h_value=0 on line 1. The registered outputs one cycle later give pixel_y=1, pixel_x=0, video_on=1, so there is no stale-line column.
- Set speed_sel=3 and run 9 frames. game_tick fires on frames 0, 4 and 8, and only together with frame_tick.
- Change speed_sel from 3 to 0 two frames after a step. The next step still occurs at the 4-frame interval, then every frame.
- Hold pause=1 across a step frame. No game_tick is issued, frame_tick is unaffected, and the following step keeps the original spacing.
- Assert rst mid-frame (line 300, h_value=400) for 3 cycles. All outputs hold their reset values during reset, and v_cnt restarts from 0 on the next strobe.
